// File: rtl/sdu_hex_loader_if.sv
// Debug load-port bundle: control/UART-byte inputs to the hex loader and the
// memory write port plus session status it drives.
interface sdu_hex_loader_if #(
    parameter int unsigned AW = 8
);
    logic          start;
    logic          sel_dm;
    logic          rx_vld;
    logic [7:0]    rx_data;
    logic [31:0]   addr;
    logic [31:0]   din;
    logic          we_im;
    logic          we_dm;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_cnt;

    modport master (
        input  start, sel_dm, rx_vld, rx_data,
        output addr, din, we_im, we_dm, busy, done, err, word_cnt
    );

    modport slave (
        output start, sel_dm, rx_vld, rx_data,
        input  addr, din, we_im, we_dm, busy, done, err, word_cnt
    );
endinterface

// File: rtl/sdu_hex_loader.sv
// Parses ASCII hex words from the UART byte stream and writes them sequentially
// into instruction or data memory through the debug load port.
module sdu_hex_loader #(
    parameter int unsigned AW     = 8,
    parameter int unsigned MAXDIG = 8
) (
    input  logic               clk,
    input  logic               rst,
    sdu_hex_loader_if.master   bus
);
    typedef enum logic [2:0] {StIdle, StCollect, StWrite, StDone, StErr} state_e;

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic [31:0]   sr_q, sr_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   wc_q, wc_d;
    logic [31:0]   din_q, din_d;
    logic          term_q, term_d;
    logic [7:0]    skid_q, skid_d;
    logic          skid_vld_q, skid_vld_d;

    logic          cur_vld;
    logic [7:0]    cur;
    logic          cur_hex;
    logic          cur_delim;
    logic [3:0]    cur_nib;
    logic          full;
    logic          last;

    // A held byte always precedes the live one so ordering is preserved.
    assign cur_vld   = skid_vld_q | bus.rx_vld;
    assign cur       = skid_vld_q ? skid_q : bus.rx_data;
    assign cur_delim = (cur == 8'h20) || (cur == 8'h0A) || (cur == 8'h0D) || (cur == 8'h2C);
    assign full      = wc_q[AW];
    assign last      = (wc_q[AW-1:0] == {AW{1'b1}});

    always_comb begin
        cur_hex = 1'b1;
        cur_nib = 4'd0;
        if (cur >= 8'h30 && cur <= 8'h39) begin
            cur_nib = cur[3:0];
        end else if ((cur >= 8'h61 && cur <= 8'h66) || (cur >= 8'h41 && cur <= 8'h46)) begin
            cur_nib = cur[3:0] + 4'd9;
        end else begin
            cur_hex = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        sr_d       = sr_q;
        dcnt_d     = dcnt_q;
        addr_d     = addr_q;
        wc_d       = wc_q;
        din_d      = din_q;
        term_d     = term_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        case (state_q)
            StCollect: begin
                if (skid_vld_q) begin
                    skid_vld_d = bus.rx_vld;
                    skid_d     = bus.rx_data;
                end
                if (cur_vld) begin
                    if (cur_hex) begin
                        if (dcnt_q == 4'(MAXDIG) || (dcnt_q == 4'd0 && full)) begin
                            state_d = StErr;
                        end else begin
                            sr_d   = {sr_q[27:0], cur_nib};
                            dcnt_d = dcnt_q + 4'd1;
                        end
                    end else if (cur_delim) begin
                        if (dcnt_q != 4'd0) begin
                            state_d = StWrite;
                            din_d   = sr_q;
                        end
                    end else if (cur == 8'h24) begin
                        if (dcnt_q != 4'd0) begin
                            state_d = StWrite;
                            din_d   = sr_q;
                            term_d  = 1'b1;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StWrite: begin
                sr_d       = '0;
                dcnt_d     = 4'd0;
                wc_d       = wc_q + 1'b1;
                skid_vld_d = bus.rx_vld;
                skid_d     = bus.rx_data;
                if (!last) begin
                    addr_d = addr_q + 1'b1;
                end
                if (term_q) begin
                    state_d    = StDone;
                    skid_vld_d = 1'b0;
                end else begin
                    state_d = StCollect;
                    // Consume a held byte now so the skid is free for the next
                    // live byte; it is interpreted as if the write had finished.
                    if (skid_vld_q) begin
                        if (cur_hex) begin
                            if (last) begin
                                state_d = StErr;
                            end else begin
                                sr_d   = {28'd0, cur_nib};
                                dcnt_d = 4'd1;
                            end
                        end else if (cur == 8'h24) begin
                            state_d = StDone;
                        end else if (!cur_delim) begin
                            state_d = StErr;
                        end
                    end
                end
            end
            default: begin
                skid_vld_d = 1'b0;
                if (bus.start) begin
                    state_d = StCollect;
                    sel_d   = bus.sel_dm;
                    sr_d    = '0;
                    dcnt_d  = 4'd0;
                    addr_d  = '0;
                    wc_d    = '0;
                    term_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= 1'b0;
            sr_q       <= '0;
            dcnt_q     <= 4'd0;
            addr_q     <= '0;
            wc_q       <= '0;
            din_q      <= '0;
            term_q     <= 1'b0;
            skid_q     <= 8'd0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            sr_q       <= sr_d;
            dcnt_q     <= dcnt_d;
            addr_q     <= addr_d;
            wc_q       <= wc_d;
            din_q      <= din_d;
            term_q     <= term_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign bus.addr     = 32'(addr_q);
    assign bus.din      = din_q;
    assign bus.we_im    = (state_q == StWrite) && !sel_q;
    assign bus.we_dm    = (state_q == StWrite) && sel_q;
    assign bus.busy     = (state_q == StCollect) || (state_q == StWrite);
    assign bus.done     = (state_q == StDone);
    assign bus.err      = (state_q == StErr);
    assign bus.word_cnt = wc_q;
endmodule

// File: tb/tb_sdu_hex_loader.sv
// Directed bench for sdu_hex_loader: an AW=8 instance for parsing/session
// scenarios and an AW=2 instance for the memory-full boundary.
module tb_sdu_hex_loader;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sdu_hex_loader_if #(.AW(8)) b8 ();
    sdu_hex_loader_if #(.AW(2)) b2 ();

    sdu_hex_loader #(.AW(8), .MAXDIG(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
    sdu_hex_loader #(.AW(2), .MAXDIG(8)) u2 (.clk(clk), .rst(rst), .bus(b2));

    logic [31:0] la8[$], ld8[$], la2[$], ld2[$];
    logic        ls8[$];
    int          both8 = 0;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (b8.we_im || b8.we_dm) begin
            la8.push_back(b8.addr);
            ld8.push_back(b8.din);
            ls8.push_back(b8.we_dm);
            if (b8.we_im && b8.we_dm) both8++;
        end
        if (b2.we_im || b2.we_dm) begin
            la2.push_back(b2.addr);
            ld2.push_back(b2.din);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_logs();
        la8.delete(); ld8.delete(); ls8.delete(); la2.delete(); ld2.delete();
    endtask

    task automatic start8(input logic sel);
        @(negedge clk);
        b8.start = 1'b1; b8.sel_dm = sel;
        @(negedge clk);
        b8.start = 1'b0;
    endtask

    task automatic send8(input string s);
        for (int i = 0; i < s.len(); i++) begin
            b8.rx_vld = 1'b1; b8.rx_data = s[i];
            @(negedge clk);
        end
        b8.rx_vld = 1'b0;
    endtask

    task automatic send2(input string s);
        for (int i = 0; i < s.len(); i++) begin
            b2.rx_vld = 1'b1; b2.rx_data = s[i];
            @(negedge clk);
        end
        b2.rx_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_tests++;
        if ({b8.busy, b8.done, b8.err, b8.we_im, b8.we_dm} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 00000",
                     {b8.busy, b8.done, b8.err, b8.we_im, b8.we_dm});
        end
        n_tests++;
        if (b8.addr !== 32'd0 || b8.din !== 32'd0 || b8.word_cnt !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_regs got addr=%h din=%h cnt=%0d want 0/0/0",
                     b8.addr, b8.din, b8.word_cnt);
        end
        rst = 1'b0;
        clr_logs();
        tick(3);
        n_tests++;
        if (la8.size() != 0 || b8.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got writes=%0d busy=%b want 0/0", la8.size(), b8.busy);
        end
    endtask

    task automatic test_imem();
        clr_logs();
        start8(1'b0);
        n_tests++;
        if (b8.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL imem_busy got %b want 1", b8.busy);
        end
        send8("00500093 00a00113$");
        tick(5);
        n_tests++;
        if (la8.size() != 2) begin
            n_fail++;
            $display("FAIL imem_count got %0d want 2", la8.size());
        end else begin
            n_tests++;
            if (la8[0] !== 32'd0 || ld8[0] !== 32'h00500093 ||
                la8[1] !== 32'd1 || ld8[1] !== 32'h00A00113) begin
                n_fail++;
                $display("FAIL imem_data got %h:%h %h:%h want 0:00500093 1:00a00113",
                         la8[0], ld8[0], la8[1], ld8[1]);
            end
            n_tests++;
            if (ls8[0] !== 1'b0 || ls8[1] !== 1'b0 || both8 != 0) begin
                n_fail++;
                $display("FAIL imem_strobe got dm=%b%b both=%0d want 00/0",
                         ls8[0], ls8[1], both8);
            end
        end
        n_tests++;
        if (b8.done !== 1'b1 || b8.busy !== 1'b0 || b8.word_cnt !== 9'd2 ||
            b8.din !== 32'h00A00113) begin
            n_fail++;
            $display("FAIL imem_end got done=%b busy=%b cnt=%0d din=%h want 1/0/2/00a00113",
                     b8.done, b8.busy, b8.word_cnt, b8.din);
        end
    endtask

    task automatic test_dmem();
        clr_logs();
        start8(1'b1);
        send8("1f,ABC\r\n$");
        tick(5);
        n_tests++;
        if (la8.size() != 2) begin
            n_fail++;
            $display("FAIL dmem_count got %0d want 2", la8.size());
        end else begin
            n_tests++;
            if (la8[0] !== 32'd0 || ld8[0] !== 32'h1F || la8[1] !== 32'd1 ||
                ld8[1] !== 32'hABC || ls8[0] !== 1'b1 || ls8[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL dmem_data got %h:%h(%b) %h:%h(%b) want 0:1f(1) 1:abc(1)",
                         la8[0], ld8[0], ls8[0], la8[1], ld8[1], ls8[1]);
            end
        end
        n_tests++;
        if (b8.done !== 1'b1 || b8.word_cnt !== 9'd2) begin
            n_fail++;
            $display("FAIL dmem_end got done=%b cnt=%0d want 1/2", b8.done, b8.word_cnt);
        end
    endtask

    task automatic test_overlong();
        clr_logs();
        start8(1'b0);
        send8("123456789 ");
        tick(3);
        n_tests++;
        if (b8.err !== 1'b1 || b8.busy !== 1'b0 || la8.size() != 0) begin
            n_fail++;
            $display("FAIL overlong got err=%b busy=%b writes=%0d want 1/0/0",
                     b8.err, b8.busy, la8.size());
        end
        start8(1'b0);
        n_tests++;
        if (b8.err !== 1'b0 || b8.busy !== 1'b1 || b8.word_cnt !== 9'd0) begin
            n_fail++;
            $display("FAIL restart got err=%b busy=%b cnt=%0d want 0/1/0",
                     b8.err, b8.busy, b8.word_cnt);
        end
        send8("$");
        tick(2);
    endtask

    task automatic test_bad_char();
        clr_logs();
        start8(1'b0);
        send8("12g4");
        tick(3);
        n_tests++;
        if (b8.err !== 1'b1 || la8.size() != 0) begin
            n_fail++;
            $display("FAIL bad_char got err=%b writes=%0d want 1/0", b8.err, la8.size());
        end
        start8(1'b0);
        send8("ff$");
        tick(5);
        n_tests++;
        if (la8.size() != 1) begin
            n_fail++;
            $display("FAIL dollar_count got %0d want 1", la8.size());
        end else begin
            n_tests++;
            if (la8[0] !== 32'd0 || ld8[0] !== 32'hFF) begin
                n_fail++;
                $display("FAIL dollar_data got %h:%h want 0:ff", la8[0], ld8[0]);
            end
        end
        n_tests++;
        if (b8.done !== 1'b1 || b8.word_cnt !== 9'd1) begin
            n_fail++;
            $display("FAIL dollar_end got done=%b cnt=%0d want 1/1", b8.done, b8.word_cnt);
        end
    endtask

    task automatic test_full();
        clr_logs();
        @(negedge clk);
        b2.start = 1'b1; b2.sel_dm = 1'b0;
        @(negedge clk);
        b2.start = 1'b0;
        send2("1 2 3 4 5");
        tick(4);
        n_tests++;
        if (la2.size() != 4) begin
            n_fail++;
            $display("FAIL full_count got %0d want 4", la2.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (la2[i] !== 32'(i) || ld2[i] !== 32'(i + 1)) begin
                    n_fail++;
                    $display("FAIL full_write%0d got %h:%h want %h:%h",
                             i, la2[i], ld2[i], 32'(i), 32'(i + 1));
                end
            end
        end
        n_tests++;
        if (b2.err !== 1'b1 || b2.word_cnt !== 3'd4 || b2.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_end got err=%b cnt=%0d busy=%b want 1/4/0",
                     b2.err, b2.word_cnt, b2.busy);
        end
    endtask

    task automatic test_rst_mid();
        start8(1'b0);
        clr_logs();
        b8.rx_vld = 1'b1; b8.rx_data = "1";
        @(negedge clk);
        b8.rx_data = " ";
        @(negedge clk);
        b8.rx_data = "2";
        @(negedge clk);
        b8.rx_data = " ";
        rst = 1'b1;
        #1;
        n_tests++;
        if (b8.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abort got busy=%b want 0", b8.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        b8.rx_vld = 1'b0;
        tick(6);
        n_tests++;
        if (la8.size() != 1) begin
            n_fail++;
            $display("FAIL rst_writes got %0d want 1", la8.size());
        end else begin
            n_tests++;
            if (la8[0] !== 32'd0 || ld8[0] !== 32'd1) begin
                n_fail++;
                $display("FAIL rst_first got %h:%h want 0:1", la8[0], ld8[0]);
            end
        end
        n_tests++;
        if (b8.din !== 32'd0 || b8.word_cnt !== 9'd0 || b8.addr !== 32'd0 ||
            {b8.busy, b8.done, b8.err} !== 3'b0) begin
            n_fail++;
            $display("FAIL rst_state got din=%h cnt=%0d addr=%h bde=%b want 0/0/0/000",
                     b8.din, b8.word_cnt, b8.addr, {b8.busy, b8.done, b8.err});
        end
    endtask

    initial begin
        rst = 1'b1;
        b8.start = 1'b0; b8.sel_dm = 1'b0; b8.rx_vld = 1'b0; b8.rx_data = 8'd0;
        b2.start = 1'b0; b2.sel_dm = 1'b0; b2.rx_vld = 1'b0; b2.rx_data = 8'd0;
        test_reset();
        test_imem();
        test_dmem();
        test_overlong();
        test_bad_char();
        test_full();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
